dmem_arbiter: RTL

Two-port arbiter that shares the HexCore single-port data memory between the pipelined core's MEM stage (port 0) and a secondary requester such as a loader/debug port (port 1). It serialises accesses with round-robin fairness and drives the synchronous-read memory port. It returns one-cycle acknowledges with read data, and produces the stall signal the core's hazard logic uses to freeze the pipeline while a port-0 access is pending.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing the single-port data memory
// between the core MEM stage (port 0) and a loader/debug port (port 1).
// One access is serviced at a time through IDLE -> ISSUE -> RESP.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  err0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err1,
    output logic                  stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } memReq_t;

    // First byte address past the end of the memory.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * MEM_WORDS);

    state_t  state, stateNext;
    logic    gnt;        // port currently being served
    logic    last;       // port served most recently (loses the next tie)
    logic    bad;        // served address is out of range
    logic    weReg;      // served access is a write
    logic    doGrant;
    logic    grantPort;
    memReq_t selReq;
    logic    selInRange;
    logic    unusedLowBits;
    logic [DATA_WIDTH-1:0] rdRet;

    // Next-state and grant selection; the acked port is never re-granted from RESP.
    always_comb begin
        stateNext = state;
        doGrant   = 1'b0;
        grantPort = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    doGrant   = 1'b1;
                    grantPort = ~last;
                end else if (req0 || req1) begin
                    doGrant   = 1'b1;
                    grantPort = req1;
                end
                if (doGrant) stateNext = ISSUE;
            end
            ISSUE: stateNext = RESP;
            RESP: begin
                if (gnt ? req0 : req1) begin
                    doGrant   = 1'b1;
                    grantPort = ~gnt;
                    stateNext = ISSUE;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign selReq        = grantPort ? '{we1, addr1, wdata1} : '{we0, addr0, wdata0};
    assign selInRange    = ({1'b0, selReq.addr} < ADDR_LIMIT);
    // Byte-offset bits are not part of a word access.
    assign unusedLowBits = ^selReq.addr[1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Grant bookkeeping and registered memory port; strobes live only in ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt       <= 1'b0;
            last      <= 1'b1;
            bad       <= 1'b0;
            weReg     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (doGrant) begin
                gnt       <= grantPort;
                bad       <= ~selInRange;
                weReg     <= selReq.we;
                mem_en    <= selInRange;
                mem_we    <= selReq.we & selInRange;
                mem_addr  <= selReq.addr[ADDR_WIDTH-1:2];
                mem_wdata <= selReq.wdata;
            end
            if (state == ISSUE) last <= gnt;
        end
    end

    // Read data is only returned for in-range reads; writes and errors give 0.
    assign rdRet  = (!weReg && !bad) ? mem_rdata : '0;

    assign ack0   = (state == RESP) && !gnt;
    assign ack1   = (state == RESP) &&  gnt;
    assign rdata0 = ack0 ? rdRet : '0;
    assign rdata1 = ack1 ? rdRet : '0;
    assign err0   = ack0 & bad;
    assign err1   = ack1 & bad;
    assign stall  = req0 & ~ack0;

endmodule
